// File: rtl/mic_volume_meter.sv
// Microphone volume meter: tracks the peak sample over a window of accepted
// samples, quantises it to a 5-bit level, and decays the level one step per
// window when the signal falls off.
module mic_volume_meter #(
    parameter int unsigned WINDOW_SAMPLES = 4000,
    parameter int unsigned BASELINE       = 2048,
    parameter int unsigned STEP_SHIFT     = 7,
    parameter int unsigned MAX_LEVEL      = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] mic_in,
    input  logic        sample_valid,
    output logic [4:0]  volume,
    output logic        volume_valid,
    output logic [11:0] peak
);

    localparam logic [15:0] LastCnt  = 16'(WINDOW_SAMPLES - 1);
    localparam logic [11:0] Baseline = 12'(BASELINE);
    localparam logic [11:0] MaxRaw   = 12'(MAX_LEVEL);
    localparam logic [4:0]  MaxLevel = 5'(MAX_LEVEL);

    logic [11:0] peak_acc_q, peak_acc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [11:0] peak_q, peak_d;
    logic [4:0]  volume_q, volume_d;
    logic        volume_valid_q, volume_valid_d;

    logic [11:0] cand;
    logic [11:0] diff;
    logic [11:0] raw;
    logic [4:0]  lvl;
    logic [4:0]  next_vol;

    // Level arithmetic: running peak including the current sample, quantised and
    // saturated, then attack-instantly / decay-one-step against the shown volume.
    always_comb begin
        cand     = (mic_in > peak_acc_q) ? mic_in : peak_acc_q;
        diff     = cand - Baseline;
        raw      = (cand > Baseline) ? (diff >> STEP_SHIFT) : 12'd0;
        lvl      = (raw > MaxRaw) ? MaxLevel : raw[4:0];
        // lvl >= 0 always, so volume_q == 0 takes the first branch: no underflow.
        next_vol = (lvl >= volume_q) ? lvl : volume_q - 5'd1;
    end

    // Next-state: accumulate within the window, publish and restart at its end.
    always_comb begin
        peak_acc_d     = peak_acc_q;
        cnt_d          = cnt_q;
        peak_d         = peak_q;
        volume_d       = volume_q;
        volume_valid_d = 1'b0;
        if (sample_valid) begin
            if (cnt_q == LastCnt) begin
                peak_d         = cand;
                volume_d       = next_vol;
                peak_acc_d     = 12'd0;
                cnt_d          = 16'd0;
                volume_valid_d = 1'b1;
            end else begin
                peak_acc_d = cand;
                cnt_d      = cnt_q + 16'd1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_acc_q     <= 12'd0;
            cnt_q          <= 16'd0;
            peak_q         <= 12'd0;
            volume_q       <= 5'd0;
            volume_valid_q <= 1'b0;
        end else begin
            peak_acc_q     <= peak_acc_d;
            cnt_q          <= cnt_d;
            peak_q         <= peak_d;
            volume_q       <= volume_d;
            volume_valid_q <= volume_valid_d;
        end
    end

    assign volume       = volume_q;
    assign volume_valid = volume_valid_q;
    assign peak         = peak_q;

endmodule

// File: tb/tb_mic_volume_meter.sv
// Directed bench for mic_volume_meter with an 8-sample window.
module tb_mic_volume_meter;

    logic        clk;
    logic        rst_n;
    logic [11:0] mic_in;
    logic        sample_valid;
    logic [4:0]  volume;
    logic        volume_valid;
    logic [11:0] peak;

    int n_checks = 0;
    int n_fails  = 0;

    logic [11:0] win [8];

    mic_volume_meter #(
        .WINDOW_SAMPLES(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mic_in      (mic_in),
        .sample_valid(sample_valid),
        .volume      (volume),
        .volume_valid(volume_valid),
        .peak        (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One accepted sample after `gap` idle cycles; returns #1 after the accept edge.
    task automatic send(input logic [11:0] v, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b1;
        mic_in       = v;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    // Send win[0..7]; no pulse may appear before the last sample, then check the
    // published result. With idle_after the pulse must drop after one cycle.
    task automatic do_window(input string tag, input int gap_max, input int exp_vol,
                             input int exp_peak, input bit idle_after);
        for (int i = 0; i < 8; i++) begin
            send(win[i], (gap_max == 0) ? 0 : ((i * 3) % (gap_max + 1)));
            if (i < 7) check({tag, " no early pulse"}, int'(volume_valid), 0);
        end
        check({tag, " valid"}, int'(volume_valid), 1);
        check({tag, " volume"}, int'(volume), exp_vol);
        check({tag, " peak"}, int'(peak), exp_peak);
        if (idle_after) begin
            @(posedge clk);
            #1;
            check({tag, " valid drops"}, int'(volume_valid), 0);
        end
    endtask

    initial begin
        // Reset held for 3 cycles while samples are offered.
        rst_n        = 1'b0;
        sample_valid = 1'b1;
        mic_in       = 12'd4095;
        repeat (3) @(posedge clk);
        #1;
        check("reset volume", int'(volume), 0);
        check("reset peak", int'(peak), 0);
        check("reset valid", int'(volume_valid), 0);
        rst_n        = 1'b1;
        sample_valid = 1'b0;

        win = '{2048, 2048, 2048, 2048, 2048, 2048, 2048, 2048};
        do_window("baseline", 0, 0, 2048, 1'b1);

        // Full-scale attack on the final sample.
        win = '{2048, 2048, 2048, 2048, 2048, 2048, 2048, 4095};
        do_window("attack", 0, 15, 4095, 1'b1);

        // Decay: back-to-back windows of 2048, one step per window.
        win = '{2048, 2048, 2048, 2048, 2048, 2048, 2048, 2048};
        for (int k = 14; k >= 0; k--) begin
            do_window($sformatf("decay %0d", k), 0, k, 2048, 1'b0);
        end
        do_window("decay floor", 0, 0, 2048, 1'b1);

        // Quantisation.
        win = '{2048, 2300, 2100, 1000, 0, 2200, 2048, 2299};
        do_window("quant 2300", 0, 1, 2300, 1'b1);
        win = '{3000, 100, 3327, 2048, 3326, 0, 4, 2500};
        do_window("quant 3327", 0, 9, 3327, 1'b1);
        win = '{2047, 0, 1000, 2000, 2047, 12, 2046, 5};
        do_window("falloff 2047", 0, 8, 2047, 1'b1);

        // Gapped strobes, peak first; 3000 -> 7, below current 8 -> decays to 7.
        win = '{3000, 2100, 2999, 0, 1500, 2048, 2900, 2500};
        do_window("gapped", 5, 7, 3000, 1'b1);

        // Reset mid-window discards the partial window.
        for (int i = 0; i < 5; i++) begin
            send(12'd4095, 0);
            check("pre-reset no pulse", int'(volume_valid), 0);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midreset volume", int'(volume), 0);
        check("midreset peak", int'(peak), 0);
        win = '{2100, 2100, 2100, 2100, 2100, 2100, 2100, 2100};
        do_window("after reset", 0, 0, 2100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mic_volume_meter.md
Name: mic_volume_meter

Overview:
- Converts the raw microphone sample stream into the 5-bit `volume` level consumed by the game/display screen-select stage.
- Sits directly upstream of that stage, between the mic capture interface and `volume`.
- Tracks the peak sample over a fixed window of accepted samples and quantises it to a level.
- Applies a one-step-per-window fall-off so the displayed level decays smoothly.

Parameters:
- WINDOW_SAMPLES, 4000: accepted samples per measurement window (0.2 s at 20 kHz); legal range 2..65535.
- BASELINE, 2048: mic DC midpoint; peaks at or below it map to level 0.
- STEP_SHIFT, 7: right-shift applied to (peak - BASELINE) to form the raw level.
- MAX_LEVEL, 15: saturation ceiling of the level; must be <= 31.

Ports:
- clk  in  1  system clock, same domain as the display/game logic
- rst_n  in  1  reset, synchronous, active-low
- mic_in  in  12  unsigned mic sample, qualified by sample_valid
- sample_valid  in  1  one-cycle strobe; mic_in is accepted on this cycle
- volume  out  5  current displayed level, 0..MAX_LEVEL
- volume_valid  out  1  one-cycle pulse, high the cycle after volume updates
- peak  out  12  raw peak of the last completed window

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
  - While rst_n=0 at a clk edge, the following are all cleared to 0: volume, volume_valid, peak, the internal peak accumulator (peak_acc) and the sample counter (cnt).
  - Reset mid-window discards the partial window; counting restarts from 0 after release.
- Cycles with sample_valid=0: all state holds.
- On each accepted sample (sample_valid=1):
  - cand = max(peak_acc, mic_in), unsigned 12-bit compare.
  - If cnt < WINDOW_SAMPLES-1: peak_acc <= cand, cnt <= cnt+1.
  - If cnt == WINDOW_SAMPLES-1 (window end), on the same edge:
    - peak <= cand
    - volume <= next_vol
    - peak_acc <= 0, cnt <= 0
    - volume_valid <= 1 (visible for exactly the next cycle, then 0)
- Level arithmetic:
  - If cand <= BASELINE: raw = 0.
  - Otherwise raw = (cand - BASELINE) >> STEP_SHIFT, computed in 12 bits.
  - lvl = min(raw, MAX_LEVEL).
- Fall-off:
  - If lvl >= volume: next_vol = lvl (instant attack).
  - Otherwise next_vol = volume - 1 (one step per window).
  - volume never underflows below 0 and never exceeds MAX_LEVEL.
- Latency:
  - volume and peak change at the edge that accepts the window's final sample.
  - volume_valid is high in the following cycle.
- Back-to-back sample_valid on consecutive cycles is legal. The first sample of the next window is accepted in the same cycle volume_valid is high.
- The final sample is always included in its own window's peak; it never leaks into the next window.
- volume is a register output with no combinational path from the inputs.

Test Plan (bench uses WINDOW_SAMPLES=8, other parameters default):
- Reset: hold rst_n=0 for 3 cycles while driving samples -> volume=0, peak=0, volume_valid=0. After release, 8 samples of 2048 -> one volume_valid pulse, volume=0, peak=2048.
- Full-scale attack: 7 samples of 2048 then one sample of 4095 -> peak=4095, volume=15 (2047>>7=15) at the 8th accept edge; volume_valid high exactly 1 cycle later.
- Quantisation and saturation:
  - window with max 2300 -> volume=1
  - window with max 3327 -> volume=9
  - window with max 2047 -> raw 0, fall-off applies: volume=8
- Decay: after volume=15, 15 windows of constant 2048 -> volume steps 14,13,...,0, one step per volume_valid pulse; a 16th window leaves volume=0.
- Gapped strobes: 8 samples with 0–5 idle cycles between strobes, peak sample 3000 placed as the 1st of the window -> peak=3000, volume=7. Exactly one volume_valid per 8 accepted samples; idle cycles do not advance cnt.
- Reset mid-window: 5 samples of 4095, pulse rst_n=0 for one cycle, then 8 samples of 2100 -> no pulse before reset; after reset one pulse with peak=2100, volume=0.
